// File: rtl/noc_pe_endpoint_if.sv
// Signal bundle for noc_pe_endpoint: local tx/rx ports plus the router-side 4-phase channels.
// Optional NOC_EP_ADDR_CHECK_EN adds the misroute status outputs.
interface noc_pe_endpoint_if;
    logic        tx_valid;
    logic        tx_ready;
    logic [1:0]  tx_dest_x;
    logic [1:0]  tx_dest_y;
    logic [24:0] tx_payload;
    logic        rx_valid;
    logic        rx_ready;
    logic [1:0]  rx_src_x;
    logic [1:0]  rx_src_y;
    logic [24:0] rx_payload;
    logic        net_out_req;
    logic        net_out_ack;
    logic [32:0] net_out_data;
    logic        net_in_req;
    logic        net_in_ack;
    logic [32:0] net_in_data;
`ifdef NOC_EP_ADDR_CHECK_EN
    logic        misroute_err;
    logic [7:0]  misroute_cnt;
`endif

    // Endpoint view.
    modport slave (
        input  tx_valid, tx_dest_x, tx_dest_y, tx_payload, rx_ready,
        input  net_out_ack, net_in_req, net_in_data,
        output tx_ready, rx_valid, rx_src_x, rx_src_y, rx_payload,
        output net_out_req, net_out_data, net_in_ack
`ifdef NOC_EP_ADDR_CHECK_EN
        , output misroute_err, misroute_cnt
`endif
    );

    // PE and router view.
    modport master (
        output tx_valid, tx_dest_x, tx_dest_y, tx_payload, rx_ready,
        output net_out_ack, net_in_req, net_in_data,
        input  tx_ready, rx_valid, rx_src_x, rx_src_y, rx_payload,
        input  net_out_req, net_out_data, net_in_ack
`ifdef NOC_EP_ADDR_CHECK_EN
        , input misroute_err, misroute_cnt
`endif
    );
endinterface

// File: rtl/noc_pe_endpoint.sv
// Clocked PE-side endpoint of a mesh router's 33-bit 4-phase bundled-data channels.
// Define NOC_EP_ADDR_CHECK_EN to drop (but still acknowledge) packets not addressed to this node.
module noc_pe_endpoint #(
    parameter logic [1:0]  MY_X         = 2'b00,
    parameter logic [1:0]  MY_Y         = 2'b00,
    parameter int unsigned RX_DEPTH     = 4,
    parameter int unsigned SETUP_CYCLES = 1
) (
    input logic              clk,
    input logic              rst,
    noc_pe_endpoint_if.slave bus
);
    localparam int AW = $clog2(RX_DEPTH);
    localparam int CW = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;
    localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYCLES - 1);

    typedef enum logic [1:0] {TX_IDLE, TX_SETUP, TX_REQ, TX_REL} tx_state_e;
    typedef enum logic {RX_WAIT_REQ, RX_ACK} rx_state_e;

    // Two-flop synchronizers for the asynchronous handshake inputs.
    logic ack_meta, ack_sync, req_meta, req_sync;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            ack_meta <= 1'b0;
            ack_sync <= 1'b0;
            req_meta <= 1'b0;
            req_sync <= 1'b0;
        end else begin
            ack_meta <= bus.net_out_ack;
            ack_sync <= ack_meta;
            req_meta <= bus.net_in_req;
            req_sync <= req_meta;
        end
    end

    // ---------------- transmit ----------------
    tx_state_e     tx_state, tx_state_d;
    logic [CW-1:0] setup_cnt, setup_cnt_d;
    logic          out_req, out_req_d;
    logic [32:0]   out_data, out_data_d;
    logic          alive;
    logic          tx_ready_int;

    // alive keeps tx_ready low through the reset edge and raises it one cycle later.
    assign tx_ready_int     = alive && (tx_state == TX_IDLE);
    assign bus.tx_ready     = tx_ready_int;
    assign bus.net_out_req  = out_req;
    assign bus.net_out_data = out_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state  <= TX_IDLE;
            setup_cnt <= '0;
            out_req   <= 1'b0;
            out_data  <= '0;
            alive     <= 1'b0;
        end else begin
            tx_state  <= tx_state_d;
            setup_cnt <= setup_cnt_d;
            out_req   <= out_req_d;
            out_data  <= out_data_d;
            alive     <= 1'b1;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path through the case leaves a variable unassigned (no latches).
        tx_state_d  = tx_state;
        setup_cnt_d = setup_cnt;
        out_req_d   = out_req;
        out_data_d  = out_data;
        unique case (tx_state)
            TX_IDLE: if (bus.tx_valid && tx_ready_int) begin
                out_data_d  = {bus.tx_dest_x, bus.tx_dest_y, MY_X, MY_Y, bus.tx_payload};
                setup_cnt_d = '0;
                tx_state_d  = TX_SETUP;
            end
            TX_SETUP: if (setup_cnt == SETUP_LAST) begin
                out_req_d  = 1'b1;
                tx_state_d = TX_REQ;
            end else begin
                setup_cnt_d = setup_cnt + 1'b1;
            end
            TX_REQ: if (ack_sync) begin
                out_req_d  = 1'b0;
                tx_state_d = TX_REL;
            end
            TX_REL: if (!ack_sync) tx_state_d = TX_IDLE;
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // ---------------- receive ----------------
    rx_state_e   rx_state, rx_state_d;
    logic        in_ack, in_ack_d;
    logic [AW:0] wr_ptr, rd_ptr;
    logic [28:0] mem [RX_DEPTH];
    logic [28:0] head;
    logic        empty, full, push, pop, can_push;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop      = !empty && bus.rx_ready;
    // A same-cycle pop frees the slot the push needs.
    assign can_push = !full || pop;
    assign head     = mem[rd_ptr[AW-1:0]];

    assign bus.rx_valid   = !empty;
    assign bus.rx_src_x   = head[28:27];
    assign bus.rx_src_y   = head[26:25];
    assign bus.rx_payload = head[24:0];
    assign bus.net_in_ack = in_ack;

`ifdef NOC_EP_ADDR_CHECK_EN
    logic       misrouted, misroute_hit, mis_err;
    logic [7:0] mis_cnt;
    assign misrouted        = (bus.net_in_data[32:29] != {MY_X, MY_Y});
    assign bus.misroute_err = mis_err;
    assign bus.misroute_cnt = mis_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            mis_err <= 1'b0;
            mis_cnt <= '0;
        end else if (misroute_hit) begin
            mis_err <= 1'b1;
            if (mis_cnt != 8'hFF) mis_cnt <= mis_cnt + 8'd1;
        end
    end
`endif

    always_comb begin
        rx_state_d = rx_state;
        in_ack_d   = in_ack;
        push       = 1'b0;
`ifdef NOC_EP_ADDR_CHECK_EN
        misroute_hit = 1'b0;
`endif
        unique case (rx_state)
            RX_WAIT_REQ: if (req_sync) begin
`ifdef NOC_EP_ADDR_CHECK_EN
                if (misrouted) begin
                    misroute_hit = 1'b1;
                    in_ack_d     = 1'b1;
                    rx_state_d   = RX_ACK;
                end else
`endif
                if (can_push) begin
                    push       = 1'b1;
                    in_ack_d   = 1'b1;
                    rx_state_d = RX_ACK;
                end
            end
            RX_ACK: if (!req_sync) begin
                in_ack_d   = 1'b0;
                rx_state_d = RX_WAIT_REQ;
            end
            default: rx_state_d = RX_WAIT_REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state <= RX_WAIT_REQ;
            in_ack   <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            rx_state <= rx_state_d;
            in_ack   <= in_ack_d;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= bus.net_in_data[28:0];
    end
endmodule
